// File: rtl/fifo_reader.sv
// Drain-side controller for the synchronous FIFO: issues reads, absorbs the one-cycle
// read latency in a 3-entry skid buffer and presents a framed valid/ready stream.
module fifo_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_LEN  = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_ren_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic [CNT_WIDTH-1:0]  frames_o,
    output logic                  busy_o
);

    localparam logic [7:0] LAST_BEAT = 8'(FRAME_LEN - 1);

    logic                  pend;
    logic [1:0]            occ;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [7:0]            beat_cnt;
    logic [DATA_WIDTH-1:0] buf_mem [3];
    logic [2:0]            inflight;
    logic                  pop;

    function automatic logic [1:0] ptr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reads are gated only by registered occupancy, never by m_ready_i,
    // so the downstream ready has no combinational path to the FIFO.
    assign inflight   = {1'b0, occ} + {2'b0, pend};
    assign fifo_ren_o = ~reset & enable_i & ~fifo_empty_i & (inflight < 3'd3);

    assign m_valid_o = (occ != 2'd0);
    assign m_last_o  = m_valid_o & (beat_cnt == LAST_BEAT);
    assign busy_o    = pend | m_valid_o;
    assign pop       = m_valid_o & m_ready_i;

    always_comb begin
        m_data_o = buf_mem[0];
        case (rd_ptr)
            2'd1:    m_data_o = buf_mem[1];
            2'd2:    m_data_o = buf_mem[2];
            default: m_data_o = buf_mem[0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend     <= 1'b0;
            occ      <= 2'd0;
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            beat_cnt <= 8'd0;
            frames_o <= '0;
            for (int i = 0; i < 3; i++) buf_mem[i] <= '0;
        end else begin
            pend <= fifo_ren_o;
            if (pend) begin
                for (int i = 0; i < 3; i++)
                    if (wr_ptr == 2'(i)) buf_mem[i] <= fifo_data_i;
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_next(rd_ptr);
            case ({pend, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
            if (pop) begin
                if (m_last_o) begin
                    beat_cnt <= 8'd0;
                    frames_o <= frames_o + CNT_WIDTH'(1);
                end else begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a behavioural FIFO feeds two readers (FRAME_LEN 4 and 1);
// every loaded word is expected out in order, framed by its index since the last reset.
module tb_fifo_reader;

    localparam int DW = 8;
    localparam int FL = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          ready = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data = '0;

    logic          ren0, valid0, last0, busy0;
    logic [DW-1:0] data0;
    logic [CW-1:0] frames0;
    logic          ren1, valid1, last1, busy1;
    logic [DW-1:0] data1;
    logic [CW-1:0] frames1;

    always #5 clk = ~clk;

    fifo_reader #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .enable_i(enable), .fifo_empty_i(fifo_empty),
        .fifo_data_i(fifo_data), .fifo_ren_o(ren0), .m_data_o(data0), .m_valid_o(valid0),
        .m_last_o(last0), .m_ready_i(ready), .frames_o(frames0), .busy_o(busy0));

    fifo_reader #(.DATA_WIDTH(DW), .FRAME_LEN(1), .CNT_WIDTH(CW)) dut1 (
        .clk(clk), .reset(reset), .enable_i(enable), .fifo_empty_i(fifo_empty),
        .fifo_data_i(fifo_data), .fifo_ren_o(ren1), .m_data_o(data1), .m_valid_o(valid1),
        .m_last_o(last1), .m_ready_i(ready), .frames_o(frames1), .busy_o(busy1));

    // Behavioural FIFO: registered read data, empty flag updated on the read edge, flushed by reset.
    logic [DW-1:0] fifo_mem [1024];
    int            wr_idx = 0;
    int            rd_idx = 0;
    assign fifo_empty = (rd_idx == wr_idx);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_idx    <= wr_idx;
            fifo_data <= '0;
        end else if (ren0) begin
            fifo_data <= fifo_mem[rd_idx % 1024];
            rd_idx    <= rd_idx + 1;
        end
    end

    logic [DW-1:0] exp_q [$];
    int            n_checks = 0;
    int            n_err = 0;
    int            beats = 0;
    int            pops_total = 0;
    logic          have_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // Monitor: mid-cycle sampling; a pop happens on the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            beats     = 0;
            have_prev = 1'b0;
        end else begin
            if (ren0) check("ren_while_empty", 32'(fifo_empty), 32'd0);
            if (ren1) check("ren1_while_empty", 32'(fifo_empty), 32'd0);
            check("frames", 32'(frames0), 32'((beats / FL) % 65536));
            check("frames_f1", 32'(frames1), 32'(beats % 65536));
            if (have_prev) begin
                check("hold_data", 32'(data0), 32'(prev_data));
                check("hold_last", 32'(last0), 32'(prev_last));
            end
            if (valid0 && ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_word actual=%0h expected=none", data0);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    check("data", 32'(data0), 32'(e));
                    check("last", 32'(last0), 32'((beats % FL) == FL - 1));
                    check("valid_f1", 32'(valid1), 32'd1);
                    check("data_f1", 32'(data1), 32'(e));
                    check("last_f1", 32'(last1), 32'd1);
                end
                beats++;
                pops_total++;
            end
            have_prev = valid0 && !ready;
            prev_data = data0;
            prev_last = last0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [DW-1:0] d);
        fifo_mem[wr_idx % 1024] = d;
        exp_q.push_back(d);
        wr_idx++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        enable = 1'b0;
        ready  = 1'b0;
        exp_q.delete();
        #1;
        check("rst_valid", 32'(valid0), 32'd0);
        check("rst_ren", 32'(ren0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_frames", 32'(frames0), 32'd0);
        check("rst_last", 32'(last0), 32'd0);
        check("rst_data", 32'(data0), 32'd0);
        step(2);
        reset = 1'b0;
    endtask

    // mode 0: ready held high, 1: toggled each cycle, 2: random
    task automatic drain(input int mode);
        int n;
        n = 0;
        while (exp_q.size() != 0 || busy0) begin
            if (n == 600) begin
                timeout_fail("drain");
                return;
            end
            case (mode)
                1:       ready = ~ready;
                2:       ready = 1'($urandom_range(0, 1));
                default: ready = 1'b1;
            endcase
            step(1);
            n++;
        end
        check("drain_busy", 32'(busy0), 32'd0);
        check("drain_busy_f1", 32'(busy1), 32'd0);
    endtask

    initial begin
        logic [11:0] ren_bits;
        logic [11:0] val_bits;
        int          rc;
        int          p0;

        // Basic burst: timing of reads and valids, frame marker on the 4th word.
        do_reset();
        load(8'h11); load(8'h22); load(8'h33); load(8'h44); load(8'h55);
        ready  = 1'b1;
        enable = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            ren_bits[k] = ren0;
            val_bits[k] = valid0;
        end
        check("t1_ren_pattern", 32'(ren_bits), 32'h01F);
        check("t1_valid_pattern", 32'(val_bits), 32'h07C);
        step(1);
        drain(0);
        check("t1_frames", 32'(frames0), 32'd1);

        // Back-pressure: three reads fill the buffer, head holds.
        do_reset();
        load(8'h11); load(8'h22); load(8'h33); load(8'h44); load(8'h55);
        ready  = 1'b0;
        enable = 1'b1;
        rc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rc += 32'(ren0);
        end
        check("t2_reads_before_stall", rc, 32'd3);
        check("t2_head", 32'(data0), 32'h11);
        check("t2_valid", 32'(valid0), 32'd1);
        step(1);
        drain(0);
        check("t2_frames", 32'(frames0), 32'd1);

        // Ready toggling over 16 words.
        do_reset();
        for (int k = 0; k < 16; k++) load(8'(8'hA0 + k));
        enable = 1'b1;
        drain(1);
        check("t3_frames", 32'(frames0), 32'd4);

        // Enable dropped after two reads; frame continues across the gap.
        do_reset();
        for (int k = 0; k < 8; k++) load(8'(8'h30 + k));
        ready  = 1'b1;
        p0     = pops_total;
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        step(10);
        check("t4_delivered", pops_total - p0, 32'd2);
        check("t4_busy", 32'(busy0), 32'd0);
        check("t4_queued", exp_q.size(), 32'd6);
        enable = 1'b1;
        drain(0);
        check("t4_frames", 32'(frames0), 32'd2);

        // Asynchronous reset mid-burst.
        do_reset();
        for (int k = 0; k < 8; k++) load(8'(8'h60 + k));
        ready  = 1'b1;
        enable = 1'b1;
        step(7);
        check("t5_frames_before", 32'(frames0), 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("t5_valid", 32'(valid0), 32'd0);
        check("t5_ren", 32'(ren0), 32'd0);
        check("t5_busy", 32'(busy0), 32'd0);
        check("t5_frames", 32'(frames0), 32'd0);
        check("t5_last", 32'(last0), 32'd0);
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) load(8'(8'h70 + k));
        enable = 1'b1;
        drain(0);
        check("t5_frames_after", 32'(frames0), 32'd1);

        // Randomized enable, ready and FIFO refill.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            enable = ($urandom_range(0, 3) != 0);
            ready  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) load(8'($urandom));
            step(1);
        end
        enable = 1'b1;
        drain(2);

        // Single-beat frames.
        do_reset();
        load(8'hC1); load(8'hC2); load(8'hC3);
        enable = 1'b1;
        drain(0);
        check("t6_frames_f1", 32'(frames1), 32'd3);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
Name: fifo_reader

Overview:
- Drain-side controller for the synchronous FIFO memory block. Issues read enables against the FIFO's empty flag and absorbs the FIFO's one-cycle registered read latency.
- Presents words on a valid/ready stream toward the bridge output, with a frame-boundary marker every FRAME_LEN beats.
- Consumer counterpart to the FIFO's write side. Sustains one word per cycle with no combinational path from downstream ready to the FIFO read enable.

Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO.
- FRAME_LEN, 4, beats per frame; legal range 1..255.
- CNT_WIDTH, 16, width of the completed-frame counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable_i  in  1  permit new FIFO reads.
- fifo_empty_i  in  1  FIFO empty flag.
- fifo_data_i  in  DATA_WIDTH  FIFO registered read data, valid the cycle after a read.
- fifo_ren_o  out  1  FIFO read enable.
- m_data_o  out  DATA_WIDTH  output word.
- m_valid_o  out  1  output word valid.
- m_last_o  out  1  last beat of the current frame.
- m_ready_i  in  1  downstream accepts the word.
- frames_o  out  CNT_WIDTH  count of completed frames; wraps modulo 2^CNT_WIDTH.
- busy_o  out  1  a read is in flight or the buffer is non-empty.

Behaviour:
- Reset: asynchronous and active-high; one clock; port names clk and reset.
  - Clears the in-flight flag, buffer occupancy, read/write pointers, beat counter and frames_o.
  - All outputs read 0 while reset is high and after reset.
  - Reset mid-operation discards in-flight and buffered words. The FIFO shares the reset, so no resynchronisation is needed.
- Internal state:
  - pend: 1-bit register; fifo_ren_o registered.
  - occ: 0..3 occupancy of a 3-entry circular skid buffer, 2-bit pointers wrapping 2->0.
  - beat_cnt: counts 0..FRAME_LEN-1.
- Read issue:
  - fifo_ren_o = enable_i & ~fifo_empty_i & ((occ + pend) < 3).
  - fifo_ren_o depends only on registers, enable_i and fifo_empty_i; it never depends on m_ready_i.
  - Never asserted while fifo_empty_i=1.
- Capture: when pend=1, fifo_data_i is written at the buffer write pointer on that edge. The issue rule guarantees free space, so overflow is unreachable.
- Output:
  - m_valid_o = (occ != 0); m_data_o = buffer head entry.
  - A pop occurs when m_valid_o & m_ready_i.
- Occupancy update:
  - Simultaneous capture and pop leaves occ unchanged.
  - Capture alone increments occ; pop alone decrements occ.
- Stream hold rule: while m_valid_o=1 and m_ready_i=0, m_data_o and m_last_o hold stable.
- Throughput and latency:
  - Steady state with m_ready_i=1 and a non-empty FIFO is one word per cycle.
  - Latency from fifo_ren_o to m_valid_o is 2 edges: the capture edge, then occ becomes non-zero.
- Framing:
  - m_last_o = m_valid_o & (beat_cnt == FRAME_LEN-1).
  - On each pop, beat_cnt increments; when m_last_o is also 1, beat_cnt wraps to 0 and frames_o increments.
  - FRAME_LEN=1: every beat is last.
  - beat_cnt is not cleared by enable_i; frames span enable gaps.
- enable_i deassert:
  - No new reads are issued.
  - The pending word is still captured and buffered words still drain.
  - busy_o falls once pend=0 and occ=0.
- Back-pressure: with m_ready_i=0, at most 3 words are held. Reads stop once occ+pend=3 and resume the cycle after a pop reduces the sum below 3.
- FIFO emptying: fifo_ren_o drops in the same cycle fifo_empty_i rises. The FIFO's registered empty flag already reflects the final read.

Test Plan:
- Reset, then FIFO preloaded with 0x11,0x22,0x33,0x44,0x55; enable_i=1; m_ready_i=1.
  - fifo_ren_o high for 5 consecutive cycles.
  - m_valid_o high for 5 consecutive cycles, starting 2 edges after the first fifo_ren_o.
  - m_data_o sequence 11,22,33,44,55; m_last_o only on 0x44; frames_o=1.
- Same preload with m_ready_i=0 for 10 cycles, then 1.
  - Exactly 3 reads issued before stall; m_data_o holds 0x11 throughout.
  - After release, all 5 words arrive in order with no loss or duplication.
- m_ready_i toggled 1/0 every cycle over 16 words (FRAME_LEN=4).
  - Output order preserved; m_last_o on beats 4,8,12,16; frames_o=4.
- enable_i dropped one cycle after the first read while 8 words are queued.
  - Only the issued words (2) are delivered; busy_o falls afterwards.
  - On re-enable, the next word continues the frame at beat_cnt=2.
- reset asserted asynchronously mid-burst, between clock edges.
  - m_valid_o, fifo_ren_o, busy_o, frames_o and m_last_o go 0 immediately.
  - After release, the first new beat has beat_cnt=0.
- FRAME_LEN=1, 3 words: m_last_o high on every beat; frames_o=3. fifo_ren_o never high while fifo_empty_i=1.
